// File: rtl/systolic_feeder.sv
// Operand feeder for a SIZE x SIZE systolic array: buffers A and B, then streams them skewed.
// Define SYSTOLIC_FEEDER_ERR_EN to build the sticky protocol-error flag driven on o_error.
module systolic_feeder #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned I_BITS = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic                     i_wr_sel,
  input  logic [$clog2(SIZE)-1:0]  i_wr_row,
  input  logic [$clog2(SIZE)-1:0]  i_wr_col,
  input  logic [I_BITS-1:0]        i_wr_data,
  input  logic                     i_start,
  input  logic [2:0]               i_matrix_size,
  output logic [SIZE*I_BITS-1:0]   o_a_full,
  output logic [SIZE*I_BITS-1:0]   o_b_full,
  output logic                     o_array_reset,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int unsigned IdxW = $clog2(SIZE);
  localparam int unsigned NW   = $clog2(SIZE + 1);
  localparam int unsigned TW   = $clog2(2 * SIZE);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  logic [NW-1:0]           n_q, n_d;
  logic [I_BITS-1:0]       a_mem [SIZE][SIZE];
  logic [I_BITS-1:0]       b_mem [SIZE][SIZE];
  logic [SIZE*I_BITS-1:0]  a_full_q, a_full_d;
  logic [SIZE*I_BITS-1:0]  b_full_q, b_full_d;
  logic                    busy_q, done_q, array_reset_q;
  logic                    wr_ok, size_ok, last;
  logic [I_BITS-1:0]       a_v, b_v;
  int                      col;

  assign wr_ok   = i_wr_en && (state_q != StStream);
  assign size_ok = (i_matrix_size != 3'd0) && (32'(i_matrix_size) <= SIZE);
  assign last    = (32'(t_q) + 32'd2) == (32'(n_q) * 32'd2);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StStream;
          t_d     = '0;
          n_d     = size_ok ? NW'(i_matrix_size) : NW'(SIZE);
        end
      end
      StStream: begin
        if (last) begin
          state_d = StDone;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lanes are computed for the next step; a write landing on the start edge is forwarded so
  // that it is visible from t=0.
  always_comb begin
    a_full_d = '0;
    b_full_d = '0;
    a_v      = '0;
    b_v      = '0;
    col      = 0;
    if (state_d == StStream) begin
      for (int k = 0; k < int'(SIZE); k++) begin
        col = int'(t_d) - k;
        if (k < int'(n_d) && col >= 0 && col < int'(n_d)) begin
          a_v = a_mem[IdxW'(k)][IdxW'(col)];
          b_v = b_mem[IdxW'(col)][IdxW'(k)];
          if (wr_ok && !i_wr_sel && i_wr_row == IdxW'(k) && i_wr_col == IdxW'(col)) begin
            a_v = i_wr_data;
          end
          if (wr_ok && i_wr_sel && i_wr_row == IdxW'(col) && i_wr_col == IdxW'(k)) begin
            b_v = i_wr_data;
          end
          a_full_d[k*I_BITS +: I_BITS] = a_v;
          b_full_d[k*I_BITS +: I_BITS] = b_v;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= StIdle;
      t_q           <= '0;
      n_q           <= NW'(SIZE);
      a_full_q      <= '0;
      b_full_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      array_reset_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      n_q           <= n_d;
      a_full_q      <= a_full_d;
      b_full_q      <= b_full_d;
      busy_q        <= (state_d == StStream);
      done_q        <= (state_d == StDone);
      array_reset_q <= (state_d == StIdle);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < int'(SIZE); r++) begin
        for (int c = 0; c < int'(SIZE); c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (i_wr_sel) begin
        b_mem[i_wr_row][i_wr_col] <= i_wr_data;
      end else begin
        a_mem[i_wr_row][i_wr_col] <= i_wr_data;
      end
    end
  end

`ifdef SYSTOLIC_FEEDER_ERR_EN
  logic error_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      error_q <= 1'b0;
    end else if ((state_q == StIdle && i_start && !size_ok) ||
                 (state_q == StStream && i_wr_en)) begin
      error_q <= 1'b1;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_a_full      = a_full_q;
  assign o_b_full      = b_full_q;
  assign o_array_reset = array_reset_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter SIZE, default 4: array dimension (lanes per operand).
REQ-002 SHALL have parameter I_BITS, default 8: operand element width.
REQ-003 SHALL have port i_clock, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port i_reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_wr_en, input, 1: write one operand element this cycle.
REQ-006 SHALL have port i_wr_sel, input, 1: 0 selects matrix A buffer, 1 selects matrix B buffer.
REQ-007 SHALL have ports i_wr_row and i_wr_col, input, $clog2(SIZE) each: element row and column.
REQ-008 SHALL have port i_wr_data, input, I_BITS: element value.
REQ-009 SHALL have port i_start, input, 1: start request, level-sampled.
REQ-010 SHALL have port i_matrix_size, input, 3: active dimension N.
REQ-011 SHALL have port o_a_full, output, SIZE*I_BITS: skewed A lanes; lane k at bits [k*I_BITS +: I_BITS].
REQ-012 SHALL have port o_b_full, output, SIZE*I_BITS: skewed B lanes, same packing.
REQ-013 SHALL have port o_array_reset, output, 1: active-high clear to the systolic array.
REQ-014 SHALL have port o_busy, output, 1: high while streaming.
REQ-015 SHALL have port o_done, output, 1: one-cycle pulse after the last stream cycle.
REQ-016 SHALL have port o_error, output, 1: sticky protocol-error flag.

Function
REQ-017 SHALL hold two SIZE x SIZE buffers (A, B); a write with i_wr_en=1 in IDLE or DONE updates the addressed element on the next edge.
REQ-018 SHALL ignore writes while in STREAM; the buffers stay unchanged.
REQ-019 SHALL implement FSM states IDLE, STREAM, DONE; IDLE -> STREAM when i_start=1; STREAM -> DONE after the last stream cycle; DONE -> IDLE unconditionally after one cycle.
REQ-020 SHALL latch N on the start edge; N=0 or N>SIZE SHALL clamp to SIZE.
REQ-021 SHALL ignore i_start in STREAM and DONE; a write and i_start in the same IDLE cycle SHALL commit the write before streaming begins.
REQ-022 SHALL run stream counter t from 0 to 2N-2 inclusive (2N-1 cycles); t=0 appears on the outputs in the first cycle after the start edge.
REQ-023 At step t, lane k of o_a_full SHALL equal A[k][t-k] and lane k of o_b_full SHALL equal B[t-k][k] when k<N and 0<=t-k<N; otherwise the lane SHALL be 0.
REQ-024 Outside STREAM, o_a_full and o_b_full SHALL be 0.
REQ-025 o_array_reset SHALL be 1 in IDLE and in the cycle of the start edge, 0 during STREAM and DONE, and 1 again from the return to IDLE.
REQ-026 o_busy SHALL equal (state==STREAM); o_done SHALL equal (state==DONE).
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 i_reset=0 SHALL immediately force state IDLE, t=0, both buffers to 0, o_a_full=0, o_b_full=0, o_busy=0, o_done=0, o_error=0 and o_array_reset=1.
REQ-029 Reset asserted mid-STREAM SHALL abort the stream with no o_done pulse; after release the block SHALL wait in IDLE.

Configuration
REQ-030 With macro SYSTOLIC_FEEDER_ERR_EN defined, o_error SHALL set on i_start with raw N=0 or N>SIZE, or on i_wr_en=1 during STREAM, and SHALL clear only on reset.
REQ-031 Without SYSTOLIC_FEEDER_ERR_EN, o_error SHALL be constant 0 and no error logic SHALL be instantiated.

Verification
REQ-032 SIZE=4, load A=B=identity, start with N=4 -> o_busy high for 7 cycles; lane k nonzero (=1) only at t=2k; o_done pulses once.
REQ-033 A[i][j]=4i+j+1, N=2 -> 3 stream cycles: t0 a=(1,0,0,0); t1 a=(2,5,0,0); t2 a=(0,6,0,0); lanes 2 and 3 stay 0 throughout.
REQ-034 Start with i_matrix_size=0 -> streaming runs with N=4 (7 cycles); o_error=1 only if SYSTOLIC_FEEDER_ERR_EN is defined.
REQ-035 Write A[0][0]=0xFF during STREAM -> buffer unchanged on the next run; o_error=1 under SYSTOLIC_FEEDER_ERR_EN.
REQ-036 Reset pulse at t=3 of an N=4 stream -> all outputs 0, o_array_reset=1, no o_done; a following start with reloaded data streams correctly.
REQ-037 i_start held high continuously -> back-to-back runs separated by exactly DONE+IDLE (2 cycles); the start is not accepted in DONE.
